// File: rtl/falafel_mem_arbiter.sv
// falafel_mem_arbiter: round-robin arbiter that shares one falafel memory port
// between NUM_REQ requesters. A tag FIFO remembers which requester issued each
// accepted request so the in-order memory responses can be steered back.
module falafel_mem_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,

  input  logic [NUM_REQ-1:0]               req_val_i,
  output logic [NUM_REQ-1:0]               req_rdy_o,
  input  logic [NUM_REQ-1:0]               req_is_write_i,
  input  logic [NUM_REQ-1:0]               req_is_cas_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_cas_exp_i,

  output logic [NUM_REQ-1:0]               rsp_val_o,
  input  logic [NUM_REQ-1:0]               rsp_rdy_i,
  output logic [DATA_W-1:0]                rsp_data_o,

  output logic                             mem_req_val_o,
  input  logic                             mem_req_rdy_i,
  output logic                             mem_req_is_write_o,
  output logic                             mem_req_is_cas_o,
  output logic [DATA_W-1:0]                mem_req_addr_o,
  output logic [DATA_W-1:0]                mem_req_data_o,
  output logic [DATA_W-1:0]                mem_req_cas_exp_o,

  input  logic                             mem_resp_val_i,
  output logic                             mem_resp_rdy_o,
  input  logic [DATA_W-1:0]                mem_resp_data_i,

  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    LOCK_FREE,
    LOCK_HELD
  } lockState_t;

  // Registered state
  logic [TAG_W-1:0] prio_q, prio_d;
  lockState_t       lockState_q, lockState_d;
  logic [TAG_W-1:0] lockIdx_q, lockIdx_d;
  logic [TAG_W-1:0] tagMem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Combinational helpers
  logic             grantAny;
  logic [TAG_W-1:0] grantIdx;
  logic             tagFull;
  logic             tagEmpty;
  logic             memReqVal;
  logic             accept;
  logic [TAG_W-1:0] head;
  logic             memRespRdy;
  logic             pop;

  // Requester index (base + off) wrapped into 0..NUM_REQ-1
  function automatic logic [TAG_W-1:0] wrapIdx(input logic [TAG_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return TAG_W'(s);
  endfunction

  assign tagFull  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign tagEmpty = (count_q == '0);

  // Grant: locked requester wins, otherwise first valid requester from prio_q onward
  always_comb begin
    grantAny = 1'b0;
    grantIdx = '0;
    if (lockState_q == LOCK_HELD) begin
      grantAny = 1'b1;
      grantIdx = lockIdx_q;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grantAny && req_val_i[wrapIdx(prio_q, i)]) begin
          grantAny = 1'b1;
          grantIdx = wrapIdx(prio_q, i);
        end
      end
    end
    if (rst_i) begin
      grantAny = 1'b0;
    end
  end

  assign memReqVal = grantAny && req_val_i[grantIdx] && !tagFull;
  assign accept    = memReqVal && mem_req_rdy_i;

  // Downstream request payload follows the grant and is zero with no grant
  always_comb begin
    mem_req_is_write_o = 1'b0;
    mem_req_is_cas_o   = 1'b0;
    mem_req_addr_o     = '0;
    mem_req_data_o     = '0;
    mem_req_cas_exp_o  = '0;
    if (grantAny) begin
      mem_req_is_write_o = req_is_write_i[grantIdx];
      mem_req_is_cas_o   = req_is_cas_i[grantIdx];
      mem_req_addr_o     = req_addr_i[grantIdx];
      mem_req_data_o     = req_data_i[grantIdx];
      mem_req_cas_exp_o  = req_cas_exp_i[grantIdx];
    end
  end

  assign mem_req_val_o = memReqVal;

  // Only the granted requester sees its request accepted
  always_comb begin
    req_rdy_o = '0;
    if (accept) begin
      req_rdy_o[grantIdx] = 1'b1;
    end
  end

  assign head = tagMem_q[rdPtr_q];

  // Route the memory response to the requester recorded at the FIFO head
  always_comb begin
    rsp_val_o  = '0;
    memRespRdy = 1'b0;
    if (!tagEmpty) begin
      rsp_val_o[head] = mem_resp_val_i;
      memRespRdy      = rsp_rdy_i[head];
    end
  end

  assign mem_resp_rdy_o = memRespRdy;
  assign rsp_data_o     = mem_resp_data_i;
  assign pop            = mem_resp_val_i && memRespRdy;
  assign outstanding_o  = count_q;

  // Next-state for priority pointer and grant lock; lock is frozen while tags are full
  always_comb begin
    prio_d      = prio_q;
    lockState_d = lockState_q;
    lockIdx_d   = lockIdx_q;
    if (accept) begin
      prio_d = wrapIdx(grantIdx, 1);
    end
    if (!tagFull) begin
      case (lockState_q)
        LOCK_FREE: begin
          if (memReqVal && !mem_req_rdy_i) begin
            lockState_d = LOCK_HELD;
            lockIdx_d   = grantIdx;
          end
        end
        LOCK_HELD: begin
          if (accept || !req_val_i[lockIdx_q]) begin
            lockState_d = LOCK_FREE;
          end
        end
        default: lockState_d = LOCK_FREE;
      endcase
    end
  end

  // Next-state for tag FIFO pointers and occupancy; push and pop may coincide
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (accept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Arbitration and FIFO control registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q      <= '0;
      lockState_q <= LOCK_FREE;
      lockIdx_q   <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
    end else begin
      prio_q      <= prio_d;
      lockState_q <= lockState_d;
      lockIdx_q   <= lockIdx_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
    end
  end

  // Tag storage: record the granted requester on every accepted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tagMem_q[i] <= '0;
      end
    end else if (accept) begin
      tagMem_q[wrPtr_q] <= grantIdx;
    end
  end

endmodule

// File: tb/tb_falafel_mem_arbiter.sv
// tb_falafel_mem_arbiter: directed scoreboard bench for the memory arbiter.
// Expected accepts and responses are queued by the stimulus thread and popped
// by a negedge monitor whenever the DUT shows a handshake.
module tb_falafel_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 4;
  localparam logic [63:0] DATA_MASK = 64'hA5A5_0000_0000_0000;

  logic                           clk;
  logic                           rst_i;
  logic [NUM_REQ-1:0]             req_val_i;
  logic [NUM_REQ-1:0]             req_rdy_o;
  logic [NUM_REQ-1:0]             req_is_write_i;
  logic [NUM_REQ-1:0]             req_is_cas_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_cas_exp_i;
  logic [NUM_REQ-1:0]             rsp_val_o;
  logic [NUM_REQ-1:0]             rsp_rdy_i;
  logic [DATA_W-1:0]              rsp_data_o;
  logic                           mem_req_val_o;
  logic                           mem_req_rdy_i;
  logic                           mem_req_is_write_o;
  logic                           mem_req_is_cas_o;
  logic [DATA_W-1:0]              mem_req_addr_o;
  logic [DATA_W-1:0]              mem_req_data_o;
  logic [DATA_W-1:0]              mem_req_cas_exp_o;
  logic                           mem_resp_val_i;
  logic                           mem_resp_rdy_o;
  logic [DATA_W-1:0]              mem_resp_data_i;
  logic [$clog2(MAX_OUT):0]       outstanding_o;

  typedef struct {
    int          idx;
    logic [63:0] val;
  } expItem_t;

  expItem_t expAcc[$];
  expItem_t expRsp[$];
  expItem_t accCur;
  expItem_t rspCur;

  int compared   = 0;
  int mismatched = 0;

  falafel_mem_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req_val_i(req_val_i),
    .req_rdy_o(req_rdy_o),
    .req_is_write_i(req_is_write_i),
    .req_is_cas_i(req_is_cas_i),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .req_cas_exp_i(req_cas_exp_i),
    .rsp_val_o(rsp_val_o),
    .rsp_rdy_i(rsp_rdy_i),
    .rsp_data_o(rsp_data_o),
    .mem_req_val_o(mem_req_val_o),
    .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_is_write_o(mem_req_is_write_o),
    .mem_req_is_cas_o(mem_req_is_cas_o),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_req_data_o(mem_req_data_o),
    .mem_req_cas_exp_o(mem_req_cas_exp_o),
    .mem_resp_val_i(mem_resp_val_i),
    .mem_resp_rdy_o(mem_resp_rdy_o),
    .mem_resp_data_i(mem_resp_data_i),
    .outstanding_o(outstanding_o)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and keep the tallies
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive both requesters (requester 1 issues CAS writes) and the downstream ready
  task automatic applyStimulus(input logic v0, input logic [63:0] a0,
                               input logic v1, input logic [63:0] a1, input logic memRdy);
    req_val_i     = {v1, v0};
    req_addr_i[0] = a0;
    req_addr_i[1] = a1;
    req_data_i[0] = a0 ^ DATA_MASK;
    req_data_i[1] = a1 ^ DATA_MASK;
    req_cas_exp_i[0] = a0 + 64'd7;
    req_cas_exp_i[1] = a1 + 64'd7;
    mem_req_rdy_i = memRdy;
  endtask

  task automatic pushAcc(input int idx, input logic [63:0] addr);
    expItem_t e;
    e.idx = idx;
    e.val = addr;
    expAcc.push_back(e);
  endtask

  task automatic pushRsp(input int idx, input logic [63:0] data);
    expItem_t e;
    e.idx = idx;
    e.val = data;
    expRsp.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Return one memory response per cycle with the given data
  task automatic memRespond(input logic [63:0] data);
    mem_resp_val_i  = 1'b1;
    mem_resp_data_i = data;
    tick();
    mem_resp_val_i  = 1'b0;
  endtask

  // Monitor: pop and compare whenever a request or response handshake is visible
  always @(negedge clk) begin
    if (!rst_i) begin
      if (mem_req_val_o && mem_req_rdy_i) begin
        if (expAcc.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_accept: got addr 0x%0h, expected no accept at %0t", mem_req_addr_o, $time);
        end else begin
          accCur = expAcc.pop_front();
          checkOutput("acc_rdy", 64'(req_rdy_o), 64'd1 << accCur.idx);
          checkOutput("acc_addr", mem_req_addr_o, accCur.val);
          checkOutput("acc_data", mem_req_data_o, accCur.val ^ DATA_MASK);
          checkOutput("acc_cas_exp", mem_req_cas_exp_o, accCur.val + 64'd7);
          checkOutput("acc_is_write", 64'(mem_req_is_write_o), 64'(accCur.idx == 1));
        end
      end
      if (mem_resp_val_i && mem_resp_rdy_o) begin
        if (expRsp.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_response: got data 0x%0h, expected no response at %0t", rsp_data_o, $time);
        end else begin
          rspCur = expRsp.pop_front();
          checkOutput("rsp_val", 64'(rsp_val_o), 64'd1 << rspCur.idx);
          checkOutput("rsp_data", rsp_data_o, rspCur.val);
        end
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    rst_i           = 1'b1;
    req_is_write_i  = 2'b10;
    req_is_cas_i    = 2'b10;
    rsp_rdy_i       = 2'b11;
    mem_resp_val_i  = 1'b0;
    mem_resp_data_i = '0;
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    #12;
    checkOutput("reset_outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("reset_mem_req_val", 64'(mem_req_val_o), 64'd0);
    checkOutput("reset_mem_resp_rdy", 64'(mem_resp_rdy_o), 64'd0);
    checkOutput("reset_addr", mem_req_addr_o, 64'd0);
    tick();
    rst_i = 1'b0;

    // Single requester read with a response two cycles later
    applyStimulus(1'b1, 64'h100, 1'b0, 64'h0, 1'b1);
    pushAcc(0, 64'h100);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    checkOutput("single_outstanding_1", 64'(outstanding_o), 64'd1);
    tick();
    mem_resp_val_i  = 1'b1;
    mem_resp_data_i = 64'hDEAD;
    pushRsp(0, 64'hDEAD);
    #1;
    checkOutput("single_rsp_val", 64'(rsp_val_o), 64'b01);
    tick();
    mem_resp_val_i = 1'b0;
    checkOutput("single_outstanding_0", 64'(outstanding_o), 64'd0);

    // Round-robin from a fresh priority pointer: 0,1,0,1
    doReset();
    applyStimulus(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1);
    pushAcc(0, 64'h1000);
    pushAcc(1, 64'h2000);
    pushAcc(0, 64'h1000);
    pushAcc(1, 64'h2000);
    repeat (4) tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("rr_outstanding", 64'(outstanding_o), 64'd4);
    pushRsp(0, 64'h11);
    pushRsp(1, 64'h22);
    pushRsp(0, 64'h33);
    pushRsp(1, 64'h44);
    memRespond(64'h11);
    mem_resp_val_i = 1'b1;
    memRespond(64'h22);
    memRespond(64'h33);
    memRespond(64'h44);
    checkOutput("rr_drained", 64'(outstanding_o), 64'd0);

    // Lock: requester 1 stalled, requester 0 must not steal the port
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h200, 1'b0);
    #1;
    checkOutput("lock_addr_c0", mem_req_addr_o, 64'h200);
    tick();
    applyStimulus(1'b1, 64'h400, 1'b1, 64'h200, 1'b0);
    #1;
    checkOutput("lock_addr_c1", mem_req_addr_o, 64'h200);
    tick();
    checkOutput("lock_addr_c2", mem_req_addr_o, 64'h200);
    tick();
    pushAcc(1, 64'h200);
    pushAcc(0, 64'h400);
    applyStimulus(1'b1, 64'h400, 1'b1, 64'h200, 1'b1);
    #1;
    checkOutput("lock_rdy_req1", 64'(req_rdy_o), 64'b10);
    tick();
    applyStimulus(1'b1, 64'h400, 1'b0, 64'h0, 1'b1);
    #1;
    checkOutput("lock_next_addr", mem_req_addr_o, 64'h400);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("lock_outstanding", 64'(outstanding_o), 64'd2);

    // Response back-pressure with tags [1, 0]
    rsp_rdy_i       = 2'b01;
    mem_resp_val_i  = 1'b1;
    mem_resp_data_i = 64'h55;
    #1;
    checkOutput("bp_resp_rdy_low", 64'(mem_resp_rdy_o), 64'd0);
    checkOutput("bp_rsp_val", 64'(rsp_val_o), 64'b10);
    tick();
    checkOutput("bp_outstanding_held", 64'(outstanding_o), 64'd2);
    checkOutput("bp_resp_rdy_still_low", 64'(mem_resp_rdy_o), 64'd0);
    rsp_rdy_i = 2'b11;
    pushRsp(1, 64'h55);
    #1;
    checkOutput("bp_resp_rdy_high", 64'(mem_resp_rdy_o), 64'd1);
    tick();
    mem_resp_data_i = 64'h66;
    pushRsp(0, 64'h66);
    #1;
    checkOutput("bp_next_route", 64'(rsp_val_o), 64'b01);
    tick();
    mem_resp_val_i = 1'b0;
    checkOutput("bp_drained", 64'(outstanding_o), 64'd0);

    // Tag full: fifth request waits until a response pops
    applyStimulus(1'b1, 64'h300, 1'b0, 64'h0, 1'b1);
    repeat (4) pushAcc(0, 64'h300);
    repeat (4) tick();
    checkOutput("full_outstanding", 64'(outstanding_o), 64'd4);
    checkOutput("full_mem_req_val", 64'(mem_req_val_o), 64'd0);
    tick();
    checkOutput("full_mem_req_val_held", 64'(mem_req_val_o), 64'd0);
    checkOutput("full_req_rdy", 64'(req_rdy_o), 64'd0);
    mem_resp_val_i  = 1'b1;
    mem_resp_data_i = 64'hA0;
    pushRsp(0, 64'hA0);
    #1;
    checkOutput("full_blocked_on_pop", 64'(mem_req_val_o), 64'd0);
    pushAcc(0, 64'h300);
    tick();
    mem_resp_val_i = 1'b0;
    #1;
    checkOutput("full_released", 64'(mem_req_val_o), 64'd1);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("full_refilled", 64'(outstanding_o), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      pushRsp(0, 64'hA0 + 64'(i));
      memRespond(64'hA0 + 64'(i));
    end
    checkOutput("full_drained", 64'(outstanding_o), 64'd0);

    // Reset mid-operation with three tags held
    applyStimulus(1'b1, 64'h500, 1'b0, 64'h0, 1'b1);
    repeat (3) pushAcc(0, 64'h500);
    repeat (3) tick();
    applyStimulus(1'b1, 64'h500, 1'b1, 64'h600, 1'b0);
    mem_resp_val_i  = 1'b1;
    mem_resp_data_i = 64'h77;
    #1;
    checkOutput("midrst_pre_outstanding", 64'(outstanding_o), 64'd3);
    checkOutput("midrst_pre_mem_req_val", 64'(mem_req_val_o), 64'd1);
    checkOutput("midrst_pre_resp_rdy", 64'(mem_resp_rdy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("midrst_mem_req_val", 64'(mem_req_val_o), 64'd0);
    checkOutput("midrst_resp_rdy", 64'(mem_resp_rdy_o), 64'd0);
    checkOutput("midrst_rsp_val", 64'(rsp_val_o), 64'd0);
    checkOutput("midrst_req_rdy", 64'(req_rdy_o), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    mem_resp_val_i = 1'b0;
    pushAcc(0, 64'h500);
    pushAcc(1, 64'h600);
    applyStimulus(1'b1, 64'h500, 1'b1, 64'h600, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("postrst_outstanding", 64'(outstanding_o), 64'd2);
    pushRsp(0, 64'hB0);
    pushRsp(1, 64'hB1);
    memRespond(64'hB0);
    memRespond(64'hB1);
    checkOutput("postrst_drained", 64'(outstanding_o), 64'd0);

    tick();
    checkOutput("acc_queue_empty", 64'(expAcc.size()), 64'd0);
    checkOutput("rsp_queue_empty", 64'(expRsp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/falafel_mem_arbiter.md
# falafel_mem_arbiter

Shares the single falafel memory port between `NUM_REQ` memory requesters, for example several `falafel_core` instances or a core plus a future sbrk unit. Requests are granted round-robin with a grant lock that holds while a handshake is in progress. A tag FIFO records which requester issued each accepted request. Memory responses, which return in request order, are steered back to that requester.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, ≥1.
- `DATA_W`, default 64: address and data width (matches `falafel_pkg::DATA_W`).
- `MAX_OUTSTANDING`, default 4: tag FIFO depth, i.e. the maximum number of accepted requests awaiting a response. Power of two, ≥2.

Ports (clock/reset: one clock; reset is asynchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-high reset.
- `req_val_i[NUM_REQ]` in 1: requester request valid.
- `req_rdy_o[NUM_REQ]` out 1: request accepted this cycle.
- `req_is_write_i[NUM_REQ]` in 1: 1 = write, 0 = read.
- `req_is_cas_i[NUM_REQ]` in 1: 1 = CAS (with is_write).
- `req_addr_i[NUM_REQ]` in DATA_W: address.
- `req_data_i[NUM_REQ]` in DATA_W: write/swap data.
- `req_cas_exp_i[NUM_REQ]` in DATA_W: CAS expected value.
- `rsp_val_o[NUM_REQ]` out 1: response valid to requester.
- `rsp_rdy_i[NUM_REQ]` in 1: requester ready for response.
- `rsp_data_o` out DATA_W: response data, shared across requesters; qualify with `rsp_val_o`.
- `mem_req_val_o`, `mem_req_rdy_i`, `mem_req_is_write_o`, `mem_req_is_cas_o`, `mem_req_addr_o`, `mem_req_data_o`, `mem_req_cas_exp_o`: downstream request. Same widths and meaning as the falafel memory port.
- `mem_resp_val_i` in 1, `mem_resp_rdy_o` out 1, `mem_resp_data_i` in DATA_W: downstream response.
- `outstanding_o` out $clog2(MAX_OUTSTANDING)+1: number of tags currently held.

## Operation
- **State:**
  - priority pointer `prio` (0..NUM_REQ-1).
  - lock flag plus `lock_idx`.
  - tag FIFO of requester indices, width $clog2(NUM_REQ), minimum 1.
- **Grant selection (combinational):**
  - If lock is set, `grant = lock_idx`.
  - Otherwise `grant` is the first requester with `req_val_i` high, searching `prio`, `prio+1`, … modulo NUM_REQ.
  - If no requester is valid, there is no grant.
- **Downstream request:**
  - `mem_req_val_o = req_val_i[grant] && !tag_full`.
  - All payload outputs mux from `grant`. With no grant, payload outputs are 0.
- **Accept:** a request is accepted when `mem_req_val_o && mem_req_rdy_i`. On accept:
  - `req_rdy_o[grant] = 1`; all other `req_rdy_o` are 0.
  - `grant` is pushed into the tag FIFO.
  - `prio <= (grant+1) mod NUM_REQ`.
  - The lock clears.
- **Lock:**
  - If `mem_req_val_o && !mem_req_rdy_i`, set lock with `lock_idx <= grant`, so the presented request cannot change mid-handshake.
  - If the locked requester drops `req_val_i` (a protocol violation), the lock clears the next cycle.
- **Tag full:** while `outstanding == MAX_OUTSTANDING`, `mem_req_val_o = 0` and no request is accepted. This holds even if a response pops in the same cycle. Lock state is held.
- **Response routing:**
  - `head` is the tag at the FIFO head.
  - `rsp_val_o[head] = mem_resp_val_i && !tag_empty`.
  - `rsp_data_o = mem_resp_data_i`.
  - `mem_resp_rdy_o = rsp_rdy_i[head] && !tag_empty`.
  - On `mem_resp_val_i && mem_resp_rdy_o`, pop the tag.
  - With the FIFO empty, `mem_resp_rdy_o = 0` and every `rsp_val_o` is 0.
- **Response count:** every accepted request (read, write, CAS) produces exactly one in-order memory response.
- **Push and pop together:** a push and a pop in the same cycle are both performed. `outstanding_o` is unchanged and the pointers wrap modulo depth.

## Timing
- **Reset values:**
  - Internal state: `prio = 0`, lock clear, FIFO empty, `outstanding_o = 0`.
  - All `req_rdy_o`, `rsp_val_o` and `mem_req_val_o` are 0; `mem_resp_rdy_o` is 0.
  - Payload outputs are 0.
- **Request path:** zero-cycle combinational pass-through. An accept occurs in the same cycle the requester's val and `mem_req_rdy_i` coincide.
- **Response path:** zero-cycle combinational, no added latency.
- **Register updates:** `prio`, lock, FIFO and `outstanding_o` update on the rising edge after the handshake.
- **Throughput:** one request per cycle and one response per cycle, sustained concurrently.
- **Reset mid-operation:** clears tags immediately. Responses still in flight from memory after reset are not routed, because `mem_resp_rdy_o = 0` while the FIFO is empty.

## Test plan
- **Single requester:** NUM_REQ=2. Req0 reads addr 0x100, `mem_req_rdy_i = 1`, memory returns 0xDEAD two cycles later.
  - Required: `req_rdy_o[0] = 1` in the request cycle, then `rsp_val_o[0] = 1` with data 0xDEAD. `rsp_val_o[1]` stays 0. `outstanding_o` goes 1 then 0.
- **Round-robin:** both requesters hold val for 4 cycles with `mem_req_rdy_i = 1`.
  - Required: grant order 0, 1, 0, 1. Four tags are pushed, in that order.
- **Lock:** req1 addr 0x200 presented while `mem_req_rdy_i = 0` for 3 cycles; req0 raises val in cycle 1.
  - Required: address stays 0x200. Req1 is accepted when rdy rises; req0 is granted the next cycle.
- **Tag full:** MAX_OUTSTANDING=4 with no responses returned; issue 5 requests.
  - Required: `outstanding_o = 4` and `mem_req_val_o = 0` on the fifth request until one response is popped.
- **Response back-pressure:** tags [1, 0], `rsp_rdy_i[1] = 0`, `mem_resp_val_i = 1` with data 0x55.
  - Required: `mem_resp_rdy_o = 0` until `rsp_rdy_i[1]` rises. Then `rsp_val_o[1]` handshakes 0x55, and the next response routes to requester 0.
- **Reset mid-operation:** assert `rst_i` asynchronously with 3 tags outstanding.
  - Required: all handshake outputs drop immediately and `outstanding_o = 0`. After reset, `prio = 0` and the grant order restarts at requester 0.
